// File: rtl/alu_datapath_unit_pkg.sv
// Shared definitions for the ALU datapath: internal ALU operations, control-field encodings,
// instruction opcode/funct constants and the data-memory byte-enable helper.
package alu_datapath_unit_pkg;

    typedef enum logic [5:0] {
        ALU_ADD  = 6'd0,
        ALU_SUB  = 6'd1,
        ALU_AND  = 6'd2,
        ALU_OR   = 6'd3,
        ALU_XOR  = 6'd4,
        ALU_NOR  = 6'd5,
        ALU_SLT  = 6'd6,
        ALU_SLTU = 6'd7,
        ALU_SLL  = 6'd8,
        ALU_SRL  = 6'd9,
        ALU_SRA  = 6'd10,
        ALU_SLLV = 6'd11,
        ALU_SRLV = 6'd12,
        ALU_SRAV = 6'd13,
        ALU_LUI  = 6'd14
    } alu_op_e;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] CTRL_ADD   = 2'b00;
    localparam logic [1:0] CTRL_SUB   = 2'b01;
    localparam logic [1:0] CTRL_RTYPE = 2'b10;
    localparam logic [1:0] CTRL_ITYPE = 2'b11;

    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Little-endian lane enables; halfword lane chosen by addr[1] only.
    function automatic logic [3:0] byte_enables(input logic [5:0] op, input logic [1:0] addr_lo);
        logic [3:0] be_v;
        case (op)
            OP_LW, OP_SW:          be_v = 4'b1111;
            OP_LH, OP_LHU, OP_SH:  be_v = addr_lo[1] ? 4'b1100 : 4'b0011;
            OP_LB, OP_LBU, OP_SB:  be_v = 4'b0001 << addr_lo;
            default:               be_v = 4'b0000;
        endcase
        return be_v;
    endfunction

endpackage

// File: rtl/alu_datapath_unit_alu_core.sv
// Pure combinational 32-bit ALU; shifts take the value from b and the amount from a[4:0].
module alu_core
    import alu_datapath_unit_pkg::*;
(
    input  alu_op_e     alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [4:0] shamt_s;
    assign shamt_s = a[4:0];

    // Operation select; fixed and variable shift forms share the same datapath.
    always_comb begin
        result = 32'd0;
        case (alu_op)
            ALU_ADD:            result = a + b;
            ALU_SUB:            result = a - b;
            ALU_AND:            result = a & b;
            ALU_OR:             result = a | b;
            ALU_XOR:            result = a ^ b;
            ALU_NOR:            result = ~(a | b);
            ALU_SLT:            result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:           result = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL, ALU_SLLV:  result = b << shamt_s;
            ALU_SRL, ALU_SRLV:  result = b >> shamt_s;
            ALU_SRA, ALU_SRAV:  result = $unsigned($signed(b) >>> shamt_s);
            ALU_LUI:            result = b;
            default:            result = a + b;
        endcase
    end

endmodule

// File: rtl/alu_datapath_unit.sv
// ALU datapath: control decode, immediate-extend select, ALU, result register and
// data-memory addressing / byte-enable generation.
module alu_datapath_unit
    import alu_datapath_unit_pkg::*;
#(
    parameter int DM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic [1:0]        alu_ctrl_op,
    input  logic [31:0]       src_a,
    input  logic [31:0]       src_b,
    output logic [1:0]        ext_op,
    output logic [31:0]       alu_result,
    output logic              zero,
    output logic [31:0]       alu_out_reg,
    output logic [3:0]        be,
    output logic [DM_AW-1:0]  dm_addr,
    output logic              mem_read_signed
);

    alu_op_e alu_op_s;

    // Map the control class plus funct/opcode onto an internal ALU operation.
    always_comb begin
        alu_op_s = ALU_ADD;
        case (alu_ctrl_op)
            CTRL_ADD: alu_op_s = ALU_ADD;
            CTRL_SUB: alu_op_s = ALU_SUB;
            CTRL_RTYPE: begin
                case (funct)
                    FN_SLL:           alu_op_s = ALU_SLL;
                    FN_SRL:           alu_op_s = ALU_SRL;
                    FN_SRA:           alu_op_s = ALU_SRA;
                    FN_SLLV:          alu_op_s = ALU_SLLV;
                    FN_SRLV:          alu_op_s = ALU_SRLV;
                    FN_SRAV:          alu_op_s = ALU_SRAV;
                    FN_JR:            alu_op_s = ALU_ADD;
                    FN_ADD, FN_ADDU:  alu_op_s = ALU_ADD;
                    FN_SUB, FN_SUBU:  alu_op_s = ALU_SUB;
                    FN_AND:           alu_op_s = ALU_AND;
                    FN_OR:            alu_op_s = ALU_OR;
                    FN_XOR:           alu_op_s = ALU_XOR;
                    FN_NOR:           alu_op_s = ALU_NOR;
                    FN_SLT:           alu_op_s = ALU_SLT;
                    FN_SLTU:          alu_op_s = ALU_SLTU;
                    default:          alu_op_s = ALU_ADD;
                endcase
            end
            CTRL_ITYPE: begin
                case (op)
                    OP_ADDI, OP_ADDIU: alu_op_s = ALU_ADD;
                    OP_SLTI:           alu_op_s = ALU_SLT;
                    OP_SLTIU:          alu_op_s = ALU_SLTU;
                    OP_ANDI:           alu_op_s = ALU_AND;
                    OP_ORI:            alu_op_s = ALU_OR;
                    OP_XORI:           alu_op_s = ALU_XOR;
                    OP_LUI:            alu_op_s = ALU_LUI;
                    default:           alu_op_s = ALU_ADD;
                endcase
            end
            default: alu_op_s = ALU_ADD;
        endcase
    end

    // Logical immediates are zero-extended, LUI pre-shifts, everything else sign-extends.
    always_comb begin
        ext_op = EXT_SIGN;
        if (alu_ctrl_op == CTRL_ITYPE) begin
            case (op)
                OP_ANDI, OP_ORI, OP_XORI: ext_op = EXT_ZERO;
                OP_LUI:                   ext_op = EXT_LUI;
                default:                  ext_op = EXT_SIGN;
            endcase
        end else begin
            ext_op = EXT_SIGN;
        end
    end

    alu_core u_alu_core (
        .alu_op (alu_op_s),
        .a      (src_a),
        .b      (src_b),
        .result (alu_result)
    );

    assign zero = (alu_result == 32'd0);

    // Result register captures every cycle; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_reg <= 32'd0;
        end else begin
            alu_out_reg <= alu_result;
        end
    end

    assign dm_addr         = {alu_out_reg[DM_AW-1:2], 2'b00};
    assign be              = byte_enables(op, alu_out_reg[1:0]);
    assign mem_read_signed = (op == OP_LB) || (op == OP_LH);

endmodule

// File: tb/tb_alu_datapath_unit.sv
// Directed self-checking bench for alu_datapath_unit with hand-computed expectations.
module tb_alu_datapath_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [1:0]  alu_ctrl_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [1:0]  ext_op;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] alu_out_reg;
    logic [3:0]  be;
    logic [11:0] dm_addr;
    logic        mem_read_signed;

    int errors;
    int checks;

    alu_datapath_unit #(.DM_AW(12)) dut (
        .clk             (clk),
        .rst             (rst),
        .op              (op),
        .funct           (funct),
        .alu_ctrl_op     (alu_ctrl_op),
        .src_a           (src_a),
        .src_b           (src_b),
        .ext_op          (ext_op),
        .alu_result      (alu_result),
        .zero            (zero),
        .alu_out_reg     (alu_out_reg),
        .be              (be),
        .dm_addr         (dm_addr),
        .mem_read_signed (mem_read_signed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [5:0] o, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        alu_ctrl_op = c;
        op          = o;
        funct       = f;
        src_a       = a;
        src_b       = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive(2'b00, 6'h00, 6'h00, 32'h0000_1111, 32'h0000_2222);
        tick();
        tick();
        check("reset_reg", alu_out_reg, 32'h0);
        check("reset_dm_addr", {20'd0, dm_addr}, 32'h0);
        rst = 1'b0;

        // R-type subtract and registration
        drive(2'b10, 6'h00, 6'h22, 32'd5, 32'd7);
        check("sub_result", alu_result, 32'hFFFF_FFFE);
        check("sub_zero", {31'd0, zero}, 32'd0);
        check("rtype_ext", {30'd0, ext_op}, 32'd1);
        tick();
        check("sub_reg", alu_out_reg, 32'hFFFF_FFFE);

        drive(2'b10, 6'h00, 6'h03, 32'd4, 32'h8000_0000);
        check("sra", alu_result, 32'hF800_0000);
        drive(2'b10, 6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1);
        check("slt", alu_result, 32'd1);
        drive(2'b10, 6'h00, 6'h2B, 32'hFFFF_FFFF, 32'd1);
        check("sltu", alu_result, 32'd0);
        drive(2'b10, 6'h00, 6'h00, 32'd4, 32'd1);
        check("sll", alu_result, 32'h0000_0010);
        drive(2'b10, 6'h00, 6'h02, 32'h0000_0024, 32'h0000_0100);
        check("srl_amt5", alu_result, 32'h0000_0010);
        drive(2'b10, 6'h00, 6'h06, 32'd8, 32'h0000_FF00);
        check("srlv", alu_result, 32'h0000_00FF);
        drive(2'b10, 6'h00, 6'h27, 32'd0, 32'd0);
        check("nor", alu_result, 32'hFFFF_FFFF);
        drive(2'b10, 6'h00, 6'h3F, 32'd1, 32'd2);
        check("funct_default_add", alu_result, 32'd3);

        // add/sub classes and wrap
        drive(2'b00, 6'h00, 6'h00, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap", alu_result, 32'd0);
        check("add_wrap_zero", {31'd0, zero}, 32'd1);
        drive(2'b01, 6'h00, 6'h00, 32'd0, 32'd1);
        check("sub_wrap", alu_result, 32'hFFFF_FFFF);

        // I-type
        drive(2'b11, 6'h0D, 6'h00, 32'h0000_0F0F, 32'h0000_F0F0);
        check("ori_ext", {30'd0, ext_op}, 32'd0);
        check("ori", alu_result, 32'h0000_FFFF);
        drive(2'b11, 6'h0F, 6'h00, 32'd5, 32'h1234_0000);
        check("lui_ext", {30'd0, ext_op}, 32'd2);
        check("lui", alu_result, 32'h1234_0000);
        drive(2'b11, 6'h0B, 6'h00, 32'd1, 32'hFFFF_FFFF);
        check("sltiu", alu_result, 32'd1);
        check("sltiu_ext", {30'd0, ext_op}, 32'd1);

        // byte enables from registered address
        drive(2'b00, 6'h20, 6'h00, 32'h0000_0400, 32'd3);
        tick();
        check("lb_be", {28'd0, be}, 32'b1000);
        check("lb_signed", {31'd0, mem_read_signed}, 32'd1);
        check("lb_dm_addr", {20'd0, dm_addr}, 32'h400);
        drive(2'b00, 6'h25, 6'h00, 32'h0000_0400, 32'd2);
        tick();
        check("lhu_be", {28'd0, be}, 32'b1100);
        check("lhu_signed", {31'd0, mem_read_signed}, 32'd0);
        drive(2'b00, 6'h21, 6'h00, 32'h0000_0400, 32'd1);
        tick();
        check("lh_be_lo", {28'd0, be}, 32'b0011);
        check("lh_signed", {31'd0, mem_read_signed}, 32'd1);
        drive(2'b00, 6'h24, 6'h00, 32'h0000_0400, 32'd1);
        check("lbu_be", {28'd0, be}, 32'b0010);
        check("lbu_signed", {31'd0, mem_read_signed}, 32'd0);
        drive(2'b00, 6'h2B, 6'h00, 32'd7, 32'd0);
        tick();
        check("sw_be", {28'd0, be}, 32'b1111);
        check("sw_dm_addr", {20'd0, dm_addr}, 32'h4);
        drive(2'b00, 6'h28, 6'h00, 32'd7, 32'd0);
        check("sb_be", {28'd0, be}, 32'b1000);
        drive(2'b00, 6'h29, 6'h00, 32'd7, 32'd0);
        check("sh_be", {28'd0, be}, 32'b1100);
        drive(2'b00, 6'h00, 6'h00, 32'd7, 32'd0);
        check("other_be", {28'd0, be}, 32'b0000);

        // reset priority over capture
        rst = 1'b1;
        drive(2'b00, 6'h20, 6'h00, 32'h0000_1234, 32'd0);
        tick();
        check("rst_reg", alu_out_reg, 32'h0);
        check("rst_dm_addr", {20'd0, dm_addr}, 32'h0);
        check("rst_be_lane0", {28'd0, be}, 32'b0001);
        check("rst_comb_result", alu_result, 32'h0000_1234);
        rst = 1'b0;
        tick();
        check("post_rst_capture", alu_out_reg, 32'h0000_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
